// File: rtl/morse_decoder.sv
// morse_decoder: times buzzer marks/spaces, classifies dots/dashes and decodes letters A-D
module morse_decoder #(
  parameter int DOT_DURATION = 3,
  parameter int DASH_THRESH  = 2 * DOT_DURATION,
  parameter int MIN_MARK     = 2,
  parameter int END_GAP      = 5 * DOT_DURATION,
  parameter int CW           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buz,
  output logic [1:0] letter,
  output logic       letter_valid,
  output logic       letter_err,
  output logic [2:0] elem_len,
  output logic [3:0] elem_bits,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    pat_q, pat_d;
  logic [2:0]    len_q, len_d;
  logic          ovf_q, ovf_d;
  logic          emit;
  logic          is_a, is_b, is_c, is_d, dec_err;
  logic [1:0]    dec_letter;
  logic [1:0]    letter_q, letter_d;
  logic          letter_valid_q, letter_valid_d;
  logic          letter_err_q, letter_err_d;
  logic [2:0]    elem_len_q, elem_len_d;
  logic [3:0]    elem_bits_q, elem_bits_d;
  // State, timing counter, captured pattern and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      pat_q          <= '0;
      len_q          <= '0;
      ovf_q          <= 1'b0;
      letter_q       <= '0;
      letter_valid_q <= 1'b0;
      letter_err_q   <= 1'b0;
      elem_len_q     <= '0;
      elem_bits_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pat_q          <= pat_d;
      len_q          <= len_d;
      ovf_q          <= ovf_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      letter_err_q   <= letter_err_d;
      elem_len_q     <= elem_len_d;
      elem_bits_q    <= elem_bits_d;
    end
  end
  // Next state: mark/space timing, element capture and end-of-letter detection
  always_comb begin
    cnt_inc = &cnt_q ? cnt_q : cnt_q + CW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    emit    = 1'b0;
    case (state_q)
      IDLE: if (buz) begin
        state_d = MARK;
        cnt_d   = CW'(1);
      end
      MARK: if (buz) cnt_d = cnt_inc;
      else if (cnt_q < CW'(MIN_MARK)) begin
        state_d = (len_q != 3'd0) ? SPACE : IDLE;
        cnt_d   = CW'(1);
      end else begin
        if (len_q[2]) ovf_d = 1'b1;
        else begin
          pat_d[len_q[1:0]] = (cnt_q >= CW'(DASH_THRESH));
          len_d             = len_q + 3'd1;
        end
        state_d = SPACE;
        cnt_d   = CW'(1);
      end
      SPACE: if (buz) begin
        state_d = MARK;
        cnt_d   = CW'(1);
      end else if (cnt_inc == CW'(END_GAP)) begin
        emit    = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
        pat_d   = '0;
        len_d   = '0;
        ovf_d   = 1'b0;
      end else cnt_d = cnt_inc;
      default: state_d = IDLE;
    endcase
  end
  // Decode the held pattern and latch results on the emitting edge
  always_comb begin
    is_a           = (len_q == 3'd2) && (pat_q == 4'b0010);
    is_b           = (len_q == 3'd4) && (pat_q == 4'b0001);
    is_c           = (len_q == 3'd4) && (pat_q == 4'b0101);
    is_d           = (len_q == 3'd3) && (pat_q == 4'b0001);
    dec_err        = ovf_q | ~(is_a | is_b | is_c | is_d);
    dec_letter     = dec_err ? 2'd0 : is_b ? 2'd1 : is_c ? 2'd2 : is_d ? 2'd3 : 2'd0;
    letter_valid_d = emit;
    letter_d       = emit ? dec_letter : letter_q;
    letter_err_d   = emit ? dec_err : letter_err_q;
    elem_len_d     = emit ? len_q : elem_len_q;
    elem_bits_d    = emit ? pat_q : elem_bits_q;
  end
  // Drive ports from registered results; busy whenever a letter is in progress
  always_comb begin
    letter       = letter_q;
    letter_valid = letter_valid_q;
    letter_err   = letter_err_q;
    elem_len     = elem_len_q;
    elem_bits    = elem_bits_q;
    busy         = (state_q != IDLE);
  end
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: randomized and directed letters checked against a symbol-string model
module tb_morse_decoder;
  localparam int MIN_MARK = 2;
  localparam int DASH_THRESH = 6;
  localparam int END_GAP = 15;
  logic clk = 1'b0, rst = 1'b1, buz = 1'b0;
  logic [1:0] letter;
  logic letter_valid, letter_err, busy;
  logic [2:0] elem_len;
  logic [3:0] elem_bits;
  int n_chk = 0, n_fail = 0;
  int mq[$], gq[$];
  string tbl[4] = '{".-", "-...", "-.-.", "-.."};
  morse_decoder dut (
    .clk(clk), .rst(rst), .buz(buz), .letter(letter), .letter_valid(letter_valid),
    .letter_err(letter_err), .elem_len(elem_len), .elem_bits(elem_bits), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input logic b);
    @(negedge clk);
    chk("no_strobe", letter_valid, 0);
    buz = b;
  endtask
  task automatic set_pat(input string p);
    mq.delete();
    gq.delete();
    for (int k = 0; k < p.len(); k++) begin
      mq.push_back(p[k] == "-" ? 9 : 3);
      gq.push_back(3);
    end
  endtask
  task automatic run_letter(input string tag);
    string s = "";
    int n, got, el;
    logic [3:0] eb = 4'b0;
    logic er;
    logic [1:0] el_l = 2'd0;
    foreach (mq[i]) if (mq[i] >= MIN_MARK) s = {s, (mq[i] >= DASH_THRESH) ? "-" : "."};
    n = s.len();
    el = (n > 4) ? 4 : n;
    for (int k = 0; k < el; k++) eb[k] = (s[k] == "-");
    er = 1'b1;
    for (int k = 0; k < 4; k++) if (n <= 4 && s == tbl[k]) begin
      er = 1'b0;
      el_l = 2'(k);
    end
    foreach (mq[i]) begin
      repeat (mq[i]) tick(1'b1);
      if (i < mq.size() - 1) repeat (gq[i]) tick(1'b0);
    end
    tick(1'b0);
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (letter_valid) begin
        got = i;
        break;
      end
    end
    if (n == 0) begin
      chk({tag, "_nostrobe"}, got, 0);
      chk({tag, "_busy"}, busy, 0);
    end else begin
      chk({tag, "_delay"}, got, END_GAP);
      chk({tag, "_letter"}, letter, el_l);
      chk({tag, "_err"}, letter_err, er);
      chk({tag, "_len"}, elem_len, el);
      chk({tag, "_bits"}, elem_bits, eb);
      chk({tag, "_busy"}, busy, 0);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", letter_valid, 0);
    chk("rst_letter", letter, 0);
    chk("rst_err", letter_err, 0);
    chk("rst_len", elem_len, 0);
    chk("rst_bits", elem_bits, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_pat(tbl[k]);
      run_letter($sformatf("dir%0d", k));
    end
    mq = '{5, 6}; gq = '{3};
    run_letter("thresh");
    mq = '{1}; gq.delete();
    run_letter("noise");
    mq = '{3, 9}; gq = '{14};
    run_letter("gap14");
    mq = '{3};
    run_letter("gap15a");
    mq = '{9};
    run_letter("gap15b");
    set_pat(".....");
    run_letter("five_dots");
    set_pat(".");
    run_letter("one_dot");
    mq = '{3, 1, 9}; gq = '{3, 3};
    run_letter("mid_noise");
    repeat (3) tick(1'b1);
    repeat (3) tick(1'b0);
    repeat (4) tick(1'b1);
    @(negedge clk);
    rst = 1'b1;
    buz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_letter", letter, 0);
    chk("mrst_err", letter_err, 0);
    chk("mrst_len", elem_len, 0);
    chk("mrst_bits", elem_bits, 0);
    chk("mrst_busy", busy, 0);
    repeat (40) tick(1'b0);
    set_pat(".-");
    run_letter("after_rst");
    for (int r = 0; r < 40; r++) begin
      mq.delete();
      gq.delete();
      if ($urandom_range(1, 0) == 1) begin
        string p = tbl[$urandom_range(3, 0)];
        for (int k = 0; k < p.len(); k++) begin
          mq.push_back(p[k] == "-" ? $urandom_range(12, 6) : $urandom_range(5, 2));
          gq.push_back($urandom_range(14, 1));
        end
      end else begin
        int nm = $urandom_range(6, 1);
        for (int k = 0; k < nm; k++) begin
          mq.push_back($urandom_range(10, 1));
          gq.push_back($urandom_range(14, 1));
        end
      end
      run_letter($sformatf("rnd%0d", r));
    end
    mq = '{70000}; gq.delete();
    run_letter("stuck");
    tick(1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
# morse_decoder

Receive-side companion to the Morse letter generators. It samples the combined buzzer line (`buz`), measures mark and space lengths in clock cycles, and classifies each mark as a dot or a dash. When the end-of-letter gap arrives, it decodes the symbol into one of letters A–D and emits a one-cycle result strobe. It sits directly downstream of the generator top level, on the same clock, and serves as the loopback checker for the buzzer path.

## Interface
- `DOT_DURATION`, 3: nominal dot length in cycles; other defaults derive from it.
- `DASH_THRESH`, 2*DOT_DURATION: a mark of at least this many cycles is a dash; shorter is a dot.
- `MIN_MARK`, 2: marks shorter than this are noise and are discarded.
- `END_GAP`, 5*DOT_DURATION: consecutive low cycles that terminate a letter.
- `CW`, 16: width of the duration counter.
- `clk` input 1: single clock.
- `rst` input 1: reset is synchronous and active-high.
- `buz` input 1: Morse stream, synchronous to `clk`; 1 = mark.
- `letter` output 2: decoded letter, 0=A, 1=B, 2=C, 3=D; 0 when `letter_err` is set.
- `letter_valid` output 1: one-cycle strobe; all result outputs are valid in this cycle.
- `letter_err` output 1: pattern was unrecognised or had more than 4 elements.
- `elem_len` output 3: number of elements captured (0–4).
- `elem_bits` output 4: captured elements; bit i = element i (first element in bit 0); 1 = dash; unused bits are 0.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, MARK, SPACE. `cnt` is CW bits wide and saturates at all-ones without wrapping.
- IDLE, `buz`=0: stay. `buz`=1: go to MARK with cnt=1.
- MARK, `buz`=1: cnt+1.
- MARK, `buz`=0, cnt<MIN_MARK: discard the mark. Go to SPACE with cnt=1 if elements are already held, otherwise go to IDLE.
- MARK, `buz`=0, cnt≥MIN_MARK: record dash if cnt≥DASH_THRESH, else dot.
  - If 4 elements are already held, set the sticky overflow flag and drop the element.
  - Otherwise store it at index `elem_len` and increment `elem_len`.
  - Go to SPACE with cnt=1.
- SPACE, `buz`=1: go to MARK with cnt=1. The same letter continues.
- SPACE, `buz`=0: cnt+1. When cnt reaches END_GAP, emit the result, clear the pattern, count and overflow flag, and go to IDLE.
- Decode table (`elem_len`/`elem_bits`):
  - A = 2/4'b0010
  - B = 4/4'b0001
  - C = 4/4'b0101
  - D = 3/4'b0001
  - Anything else, or overflow, gives `letter_err`=1 and `letter`=0.
- A stuck-high `buz` stays in MARK with a saturated cnt and produces no output.

## Timing
- Reset: state IDLE; `letter`=0, `letter_valid`=0, `letter_err`=0, `elem_len`=0, `elem_bits`=0, `busy`=0; cnt, pattern and overflow cleared.
- `rst` has priority over everything. Reset mid-letter discards the partial letter and produces no strobe.
- `buz` is sampled on every `posedge clk` with no input synchroniser.
- The `letter_valid` strobe is registered. It is high for exactly one cycle, starting in the cycle after the edge that samples the END_GAP-th consecutive low (counting the first low after the last mark).
- `letter`, `letter_err`, `elem_len` and `elem_bits` are registered and updated in the same cycle as `letter_valid`. They hold their values until the next strobe or reset.
- `busy` goes high the cycle after the first accepted high sample and low the cycle after the emitting edge.
- A noise-only burst (a sub-MIN_MARK mark while IDLE) causes no strobe.
- Back-to-back letters: a mark arriving on the cycle after the strobe starts a new letter normally.

## Test plan
- A: `buz` = 3 high, 3 low, 9 high, then low.
  - Required: `letter_valid` pulses once, 15 cycles after the fall, with `letter`=0, `elem_len`=2, `elem_bits`=4'b0010, `letter_err`=0.
- B, C, D: the same timing pattern with 3-cycle dots, 9-cycle dashes and 3-cycle gaps.
  - B gives `letter` 1, `elem_bits` 4'b0001, `elem_len` 4.
  - C gives `letter` 2, `elem_bits` 4'b0101, `elem_len` 4.
  - D gives `letter` 3, `elem_bits` 4'b0001, `elem_len` 3.
- Thresholds:
  - A 5-cycle mark classifies as a dot; a 6-cycle mark classifies as a dash.
  - A 1-cycle pulse alone produces no strobe and `busy` returns to 0.
  - A 14-low gap followed by a mark continues the same letter; 15 lows ends it.
- Errors:
  - 5 dots give one strobe with `letter_err`=1, `letter`=0, `elem_len`=4.
  - A single dot gives `letter_err`=1, `elem_len`=1.
- Reset mid-letter: assert `rst` for 1 cycle during the dash of A.
  - Required: no strobe and all outputs 0.
  - A following clean A then decodes correctly.
- Stuck high: hold `buz`=1 for 70000 cycles, then drive low.
  - Required: cnt saturates, the mark is classified as a dash, and an err strobe (pattern 1/4'b0001) appears 15 cycles after the fall.
